// File: rtl/rs_encoder_if.sv
// Handshake bundle between the framer (master) and the RS(198,194) encoder (slave).
interface rs_encoder_if;
  logic        rs_ena;
  logic        tx_vld;
  logic [63:0] tx_data;
  logic        tx_rdy;
  logic        enc_vld;
  logic [63:0] enc_data;

  modport master (output rs_ena, tx_vld, tx_data, input tx_rdy, enc_vld, enc_data);
  modport slave  (input rs_ena, tx_vld, tx_data, output tx_rdy, enc_vld, enc_data);
endinterface

// File: rtl/rs_encoder.sv
// RS(198,194) encoder over GF(2^8): 97 input words -> 99-word superframe of 4 codewords,
// 4 parity bytes spliced in after every 194 data bytes.
module rs_encoder #(
  parameter int CW_DATA = 194
) (
  input logic          clk,
  input logic          rstn,
  rs_encoder_if.slave  bus
);
  localparam logic [6:0] LAST = 7'(((CW_DATA + 4) * 4) / 8 - 1);

  logic [6:0]  idx_q, idx_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] res_q, res_d;
  logic        mode_q;
  logic        enc_vld_q;
  logic [63:0] enc_data_q;
  logic [63:0] word_d, in;
  logic [31:0] par;
  logic        enc, stall, fire;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // Feeds the first n bytes of d (MSB first) through the g(x) remainder register.
  function automatic logic [31:0] lfsr_step(input logic [31:0] r, input logic [63:0] d, input int n);
    logic [31:0] s;
    logic [7:0]  fb;
    s = r;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        fb = d[63-8*i -: 8] ^ s[31:24];
        s  = {s[23:16] ^ gf_mul(fb, 8'h0F), s[15:8] ^ gf_mul(fb, 8'h36),
              s[7:0] ^ gf_mul(fb, 8'h78), gf_mul(fb, 8'h40)};
      end
    end
    return s;
  endfunction

  always_comb begin
    in     = bus.tx_data;
    // Mode only changes at the superframe boundary, so rs_ena is looked at live there.
    enc    = (idx_q == 7'd0) ? bus.rs_ena : mode_q;
    stall  = mode_q && (idx_q == 7'd49 || idx_q == LAST);
    fire   = stall || bus.tx_vld;
    word_d = in;
    lfsr_d = lfsr_q;
    res_d  = res_q;
    idx_d  = idx_q;
    par    = '0;
    if (enc && fire) begin
      idx_d = (idx_q == LAST) ? 7'd0 : idx_q + 7'd1;
      if (idx_q == 7'd24) begin
        par    = lfsr_step(lfsr_q, in, 2);
        word_d = {in[63:48], par, in[47:32]};
        lfsr_d = lfsr_step('0, {in[47:32], 48'h0}, 2);
        res_d  = in[31:0];
      end else if (idx_q == 7'd49) begin
        word_d = {lfsr_q, res_q};
        lfsr_d = lfsr_step('0, {res_q, 32'h0}, 4);
        res_d  = '0;
      end else if (idx_q == 7'd73) begin
        // Parity is split across words 73/74; the remainder register carries the tail half.
        par    = lfsr_step(lfsr_q, in, 6);
        word_d = {in[63:16], par[31:16]};
        lfsr_d = par;
        res_d  = {in[15:0], 16'h0};
      end else if (idx_q == 7'd74) begin
        word_d = {lfsr_q[15:0], res_q[31:16], in[63:32]};
        lfsr_d = lfsr_step('0, {res_q[31:16], in[63:32], 16'h0}, 6);
        res_d  = in[31:0];
      end else if (idx_q == LAST) begin
        par    = lfsr_step(lfsr_q, {res_q, 32'h0}, 4);
        word_d = {res_q, par};
        lfsr_d = '0;
        res_d  = '0;
      end else if (idx_q < 7'd24 || (idx_q > 7'd49 && idx_q < 7'd73)) begin
        word_d = in;
        lfsr_d = lfsr_step(lfsr_q, in, 8);
      end else begin
        word_d = {res_q, in[63:32]};
        lfsr_d = lfsr_step(lfsr_q, word_d, 8);
        res_d  = in[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q      <= '0;
      lfsr_q     <= '0;
      res_q      <= '0;
      mode_q     <= 1'b0;
      enc_vld_q  <= 1'b0;
      enc_data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
      res_q  <= res_d;
      mode_q <= enc;
      if (enc) begin
        enc_vld_q <= fire;
        if (fire) enc_data_q <= word_d;
      end else begin
        enc_vld_q  <= bus.tx_vld;
        enc_data_q <= bus.tx_data;
      end
    end
  end

  assign bus.tx_rdy   = !stall;
  assign bus.enc_vld  = enc_vld_q;
  assign bus.enc_data = enc_data_q;
endmodule
